// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - PS/2 receiver bus: raw line inputs and decoded scan code outputs
interface ps2_rx_if;
    logic       ps2_clock;
    logic       ps2_data;
    logic [7:0] ps2_code;
    logic       ps2_code_new;
    logic       frame_error;
    logic       rx_busy;

    modport master (
        output ps2_clock, ps2_data,
        input  ps2_code, ps2_code_new, frame_error, rx_busy
    );

    modport slave (
        input  ps2_clock, ps2_data,
        output ps2_code, ps2_code_new, frame_error, rx_busy
    );
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with clock glitch filter and frame timeout
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic    clock,
    input  logic    reset,
    ps2_rx_if.slave bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] stab_cnt;
    logic          fall;

    state_t        state;
    logic [3:0]    bit_idx;
    logic [7:0]    shift;
    logic          parity_bit;
    logic          stop_bit;
    logic [TW-1:0] timer;
    logic [7:0]    code_r;
    logic          code_new_r;
    logic          error_r;
    logic          busy_r;

    assign fall = clk_filt_d & ~clk_filt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            stab_cnt   <= '0;
        end else begin
            clk_s1     <= bus.ps2_clock;
            clk_s2     <= clk_s1;
            dat_s1     <= bus.ps2_data;
            dat_s2     <= dat_s1;
            clk_filt_d <= clk_filt;
            if (clk_s2 == clk_filt) begin
                stab_cnt <= '0;
            end else if (stab_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            stop_bit   <= 1'b0;
            timer      <= '0;
            code_r     <= '0;
            code_new_r <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            code_new_r <= 1'b0;
            error_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && !dat_s2) begin
                        state   <= RECEIVE;
                        busy_r  <= 1'b1;
                        bit_idx <= '0;
                        timer   <= '0;
                    end
                end
                RECEIVE: begin
                    // A sample event always beats a timeout landing in the same cycle.
                    if (fall) begin
                        timer   <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx < 4'd8) begin
                            shift <= {dat_s2, shift[7:1]};
                        end else if (bit_idx == 4'd8) begin
                            parity_bit <= dat_s2;
                        end else begin
                            stop_bit <= dat_s2;
                            state    <= CHECK;
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 2)) begin
                        // Fires one cycle early so the registered pulse lands
                        // TIMEOUT_CYCLES after the last sample event.
                        error_r <= 1'b1;
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    if ((^shift ^ parity_bit) && stop_bit) begin
                        code_r     <= shift;
                        code_new_r <= 1'b1;
                    end else begin
                        error_r <= 1'b1;
                    end
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ps2_code     = code_r;
    assign bus.ps2_code_new = code_new_r;
    assign bus.frame_error  = error_r;
    assign bus.rx_busy      = busy_r;
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter: FILTER_LEN, 8, consecutive equal synchronized ps2_clock samples required to change the filtered clock level.
REQ-002 Parameter: TIMEOUT_CYCLES, 50000, clock cycles allowed between falling edges inside a frame (1 ms at 50 MHz).
REQ-003 Port: clock  input  1  system clock (50 MHz); one clock domain only.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: ps2_clock  input  1  raw PS/2 clock line, asynchronous to clock.
REQ-006 Port: ps2_data  input  1  raw PS/2 data line, asynchronous to clock.
REQ-007 Port: ps2_code  output  8  last correctly received scan code byte.
REQ-008 Port: ps2_code_new  output  1  one-cycle pulse when ps2_code has been updated.
REQ-009 Port: frame_error  output  1  one-cycle pulse on a parity, stop-bit or timeout failure.
REQ-010 Port: rx_busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-011 ps2_clock and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 Filtered clock SHALL change level only after the synchronized clock has held the opposite level for FILTER_LEN consecutive cycles; the stability counter clears on any mismatch.
REQ-013 Sample event: a 1->0 transition of the filtered clock; one cycle wide; data sampled is the synchronized ps2_data in that cycle.
REQ-014 States: IDLE, RECEIVE, CHECK.
REQ-015 IDLE: sample event with data=0 -> RECEIVE, bit index=0; sample event with data=1 is ignored with no error.
REQ-016 RECEIVE: indices 0-7 are data bits shifted in LSB first, index 8 is parity, index 9 is stop; after the stop-bit sample the state goes to CHECK.
REQ-017 CHECK lasts exactly one cycle, then the state returns to IDLE.
REQ-018 Valid frame: XOR of the 8 data bits and the parity bit = 1 (odd parity), and stop bit = 1.
REQ-019 Valid frame in CHECK: ps2_code <= data byte and ps2_code_new pulses in the next cycle; ps2_code holds until the next valid frame.
REQ-020 Latency: ps2_code_new rises exactly 2 cycles after the stop-bit sample event.
REQ-021 Invalid frame in CHECK: frame_error pulses for one cycle in the next cycle; ps2_code is unchanged and ps2_code_new stays 0.
REQ-022 Timeout counter: cleared on entry to RECEIVE and on every sample event; increments every cycle in RECEIVE.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES: frame_error pulses once, partial bits are discarded, and the state goes to IDLE.
REQ-024 A sample event and timeout in the same cycle: the sample event wins and the counter clears.
REQ-025 ps2_code_new and frame_error SHALL never be high in the same cycle, and each SHALL be high for at most 1 cycle per frame.
REQ-026 Back-to-back frames SHALL each produce their own pulse; CHECK does not block a start bit arriving in the following cycle.
REQ-027 Outputs SHALL be registered.

Reset
REQ-028 Reset SHALL put the block in state IDLE with ps2_code=0x00, ps2_code_new=0, frame_error=0 and rx_busy=0.
REQ-029 Reset SHALL set the synchronizer flops and the filtered clock to 1 (idle bus) and clear the stability, bit and timeout counters.
REQ-030 Reset mid-frame SHALL discard the partial frame with no pulse on ps2_code_new or frame_error, both during reset and after it deasserts.

Verification
REQ-031 Frame 0x1D, parity 1, stop 1 at 10 kHz PS/2 clock -> ps2_code=0x1D and one ps2_code_new pulse 2 cycles after the stop-bit edge; frame_error stays 0.
REQ-032 Frame 0x1D with parity 0 -> one frame_error pulse; ps2_code keeps its prior value; no ps2_code_new.
REQ-033 Frames 0xF0 (parity 1) then 0x1C (parity 0), back-to-back -> two ps2_code_new pulses, with ps2_code 0xF0 then 0x1C.
REQ-034 A ps2_clock low glitch of FILTER_LEN-2 cycles during IDLE and mid-frame -> no sample event, no bit-index change; the frame still decodes correctly.
REQ-035 Start bit plus 5 data bits, then the bus stays idle -> frame_error pulses exactly TIMEOUT_CYCLES cycles after the 5th edge and rx_busy drops; the next full frame 0x29 (parity 0) decodes correctly.
REQ-036 Reset asserted after the 4th data bit, then released -> outputs at reset values, no pulses; the following frame 0x1B (parity 1) decodes correctly.
